fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core, directly upstream of the main/ALU decoder.
- Owns the PC and drives a request/ready instruction-memory port.
- Registers the fetched word into IF/ID; the decoder takes op = instr_d[31:26] and funct = instr_d[5:0].
- Consumes the decoder's pcsrc and jump {jal, jr, j} outputs to redirect fetch. There are no branch delay slots.

---
 rtl/fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
//
// This block owns the PC and drives a request/ready instruction-memory port. Each word that
// completes is registered into IF/ID for the decoder. Redirects come back from the decoder
// (pcsrc_d, jump_d = {jal, jr, j}). There are no branch delay slots, so a redirect squashes
// the word fetched alongside it and inserts a single bubble.
//
// Ports:
//   clk, reset             core clock; synchronous active-high reset
//   stall_d                hazard-unit stall: hold IF/ID and suppress redirect
//   pcsrc_d, jump_d        redirect controls for the instruction in D
//   pcbranch_d, rd1_d      branch target / JR target for the instruction in D
//   imem_req, imem_addr    fetch request and address (address = pc_f)
//   imem_ready, imem_rdata memory accepts the request; the word returns in the same cycle
//   pc_f                   current fetch PC
//   instr_d, pcplus4_d     IF/ID instruction word and its PC+4
//   valid_d                IF/ID holds a real instruction (a bubble is word 0, i.e. sll $0)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        pcsrc_d,
    input  logic [2:0]  jump_d,
    input  logic [31:0] pcbranch_d,
    input  logic [31:0] rd1_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d
);

    // StDrop: a request for a squashed path is still outstanding.
    // StHold: one word is parked in the skid buffer and no request is issued.
    typedef enum logic [1:0] {StFetch, StDrop, StHold} state_t;

    state_t      state, state_next;
    logic [31:0] pc_next, instr_next, pcplus4_next;
    logic        valid_next;
    logic [31:0] skid_instr, skid_instr_next;
    logic [31:0] skid_pcplus4, skid_pcplus4_next;
    logic [31:0] pending, pending_next;

    logic        redir;
    logic        jr_sel, j_sel;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        fire;

    assign imem_req  = ~reset & (state != StHold);
    assign imem_addr = pc_f;
    assign fire      = imem_req & imem_ready;
    assign pc_plus4  = pc_f + 32'd4;  // wraps modulo 2^32

    assign redir  = valid_d & ~stall_d & (pcsrc_d | (|jump_d));
    assign jr_sel = jump_d[1];
    assign j_sel  = jump_d[2] | jump_d[0];

    // jr beats j/jal, which beat a taken branch.
    always_comb begin
        if (jr_sel) begin
            target = rd1_d;
        end else if (j_sel) begin
            target = {pcplus4_d[31:28], instr_d[25:0], 2'b00};
        end else begin
            target = pcbranch_d;
        end
    end

    always_comb begin
        state_next        = state;
        pc_next           = pc_f;
        instr_next        = instr_d;
        pcplus4_next      = pcplus4_d;
        valid_next        = valid_d;
        skid_instr_next   = skid_instr;
        skid_pcplus4_next = skid_pcplus4;
        pending_next      = pending;

        unique case (state)
            StFetch: begin
                if (fire) begin
                    if (redir) begin
                        // The returned word belongs to the wrong path.
                        pc_next      = target;
                        instr_next   = 32'd0;
                        pcplus4_next = 32'd0;
                        valid_next   = 1'b0;
                    end else if (stall_d) begin
                        skid_instr_next   = imem_rdata;
                        skid_pcplus4_next = pc_plus4;
                        pc_next           = pc_plus4;
                        state_next        = StHold;
                    end else begin
                        instr_next   = imem_rdata;
                        pcplus4_next = pc_plus4;
                        valid_next   = 1'b1;
                        pc_next      = pc_plus4;
                    end
                end else if (redir) begin
                    // The address must stay put until the outstanding request completes.
                    pending_next = target;
                    instr_next   = 32'd0;
                    pcplus4_next = 32'd0;
                    valid_next   = 1'b0;
                    state_next   = StDrop;
                end else if (!stall_d) begin
                    instr_next   = 32'd0;
                    pcplus4_next = 32'd0;
                    valid_next   = 1'b0;
                end
            end
            StDrop: begin
                if (fire) begin
                    pc_next    = pending;
                    state_next = StFetch;
                end
                if (!stall_d) begin
                    instr_next   = 32'd0;
                    pcplus4_next = 32'd0;
                    valid_next   = 1'b0;
                end
            end
            StHold: begin
                if (!stall_d) begin
                    state_next = StFetch;
                    if (redir) begin
                        pc_next      = target;
                        instr_next   = 32'd0;
                        pcplus4_next = 32'd0;
                        valid_next   = 1'b0;
                    end else begin
                        instr_next   = skid_instr;
                        pcplus4_next = skid_pcplus4;
                        valid_next   = 1'b1;
                    end
                end
            end
            default: begin
                state_next = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StFetch;
            pc_f         <= RESET_PC;
            instr_d      <= 32'd0;
            pcplus4_d    <= 32'd0;
            valid_d      <= 1'b0;
            skid_instr   <= 32'd0;
            skid_pcplus4 <= 32'd0;
            pending      <= 32'd0;
        end else begin
            state        <= state_next;
            pc_f         <= pc_next;
            instr_d      <= instr_next;
            pcplus4_d    <= pcplus4_next;
            valid_d      <= valid_next;
            skid_instr   <= skid_instr_next;
            skid_pcplus4 <= skid_pcplus4_next;
            pending      <= pending_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized traffic, all checked every cycle
// against a behavioural model of the fetch stage kept in this bench.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_d;
    logic        pcsrc_d;
    logic [2:0]  jump_d;
    logic [31:0] pcbranch_d;
    logic [31:0] rd1_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall_d    (stall_d),
        .pcsrc_d    (pcsrc_d),
        .jump_d     (jump_d),
        .pcbranch_d (pcbranch_d),
        .rd1_d      (rd1_d),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc_f       (pc_f),
        .instr_d    (instr_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d)
    );

    always #5 clk = ~clk;

    // Reference state: what sits in D, where fetch goes next, an optional parked word and an
    // optional squashed request still in flight.
    logic [31:0] m_pc = 0, m_instr = 0, m_pc4 = 0;
    logic        m_valid = 0;
    logic        m_parked = 0;
    logic [31:0] m_park_instr = 0, m_park_pc4 = 0;
    logic        m_squashed = 0;
    logic [31:0] m_after_squash = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h2009_0003;
            32'h1000_0000: return 32'h0800_0010;  // j with target field 0x10
            default:       return {a[7:0], a[31:8]} ^ 32'h5A5A_1234;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check the request side, advance the model, check IF/ID and PC.
    task automatic step(input logic rst, input logic rdy, input logic stl, input logic psrc,
                        input logic [2:0] jmp, input logic [31:0] pcb, input logic [31:0] r1);
        logic        exp_req, take, done;
        logic [31:0] dest, word;
        @(negedge clk);
        reset      = rst;
        imem_ready = rdy;
        stall_d    = stl;
        pcsrc_d    = psrc;
        jump_d     = jmp;
        pcbranch_d = pcb;
        rd1_d      = r1;
        word       = rdy ? mem_word(m_pc) : $urandom;
        imem_rdata = word;
        #1;
        exp_req = !rst && !m_parked;
        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check("imem_addr", imem_addr, m_pc);

        take = m_valid && !stl && (psrc || jmp != 3'b000);
        if (jmp[1])                 dest = r1;
        else if (jmp[2] || jmp[0])  dest = {m_pc4[31:28], m_instr[25:0], 2'b00};
        else                        dest = pcb;
        done = exp_req && rdy;

        if (rst) begin
            m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0;
            m_parked = 0; m_squashed = 0;
        end else if (m_parked) begin
            if (!stl) begin
                m_parked = 0;
                if (take) begin
                    m_pc = dest; m_instr = 0; m_pc4 = 0; m_valid = 0;
                end else begin
                    m_instr = m_park_instr; m_pc4 = m_park_pc4; m_valid = 1;
                end
            end
        end else if (m_squashed) begin
            if (done) begin
                m_pc = m_after_squash; m_squashed = 0;
            end
            if (!stl) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end
        end else if (take) begin
            if (done) m_pc = dest;
            else begin
                m_after_squash = dest; m_squashed = 1;
            end
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (done) begin
            if (stl) begin
                m_park_instr = word; m_park_pc4 = m_pc + 4; m_parked = 1;
            end else begin
                m_instr = word; m_pc4 = m_pc + 4; m_valid = 1;
            end
            m_pc = m_pc + 4;
        end else if (!stl) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end

        @(posedge clk);
        #1;
        check("pc_f", pc_f, m_pc);
        check("instr_d", instr_d, m_instr);
        check("pcplus4_d", pcplus4_d, m_pc4);
        check("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    endtask

    initial begin
        reset = 1; stall_d = 0; pcsrc_d = 0; jump_d = 0; pcbranch_d = 0; rd1_d = 0;
        imem_ready = 0; imem_rdata = 0;

        // Reset and zero-wait streaming.
        step(1, 0, 0, 0, 3'b000, 0, 0);
        step(1, 1, 0, 0, 3'b000, 0, 0);
        check("reset_valid", {31'd0, valid_d}, 32'd0);
        step(0, 1, 0, 0, 3'b000, 0, 0);
        check("t1_instr0", instr_d, 32'h2008_0005);
        check("t1_pc4_0", pcplus4_d, 32'h4);
        step(0, 1, 0, 0, 3'b000, 0, 0);
        check("t1_instr1", instr_d, 32'h2009_0003);
        check("t1_pc_f", pc_f, 32'h8);

        // Stall while the word at 0x8 returns.
        step(0, 1, 1, 0, 3'b000, 0, 0);
        step(0, 1, 1, 0, 3'b000, 0, 0);
        check("t2_hold_req", {31'd0, imem_req}, 32'd0);
        step(0, 0, 0, 0, 3'b000, 0, 0);
        check("t2_instr", instr_d, mem_word(32'h8));
        check("t2_pc4", pcplus4_d, 32'hC);

        // Taken branch.
        step(0, 1, 0, 1, 3'b000, 32'h40, 0);
        check("t3_bubble", {31'd0, valid_d}, 32'd0);
        check("t3_pc", pc_f, 32'h40);
        step(0, 1, 0, 0, 3'b000, 0, 0);
        check("t3_instr", instr_d, mem_word(32'h40));

        // JR beats a simultaneous branch; J target formation.
        step(0, 1, 0, 1, 3'b010, 32'h200, 32'h100);
        check("t4_jr", pc_f, 32'h100);
        step(0, 1, 0, 0, 3'b000, 0, 0);
        step(0, 1, 0, 1, 3'b000, 32'h1000_0000, 0);
        step(0, 1, 0, 0, 3'b000, 0, 0);
        check("t4_jword", instr_d, 32'h0800_0010);
        step(0, 1, 0, 0, 3'b001, 0, 0);
        check("t4_j", pc_f, 32'h1000_0040);

        // Wait states with a redirect during the wait.
        step(0, 1, 0, 0, 3'b000, 0, 0);
        step(0, 0, 1, 0, 3'b000, 0, 0);
        step(0, 0, 0, 1, 3'b000, 32'h80, 0);
        step(0, 0, 0, 0, 3'b000, 0, 0);
        check("t5_addr_held", imem_addr, 32'h1000_0044);
        step(0, 1, 0, 0, 3'b000, 0, 0);
        check("t5_dropped", {31'd0, valid_d}, 32'd0);
        check("t5_pc", pc_f, 32'h80);
        step(0, 1, 0, 0, 3'b000, 0, 0);
        check("t5_instr", instr_d, mem_word(32'h80));

        // PC wrap, then reset during HOLD.
        step(0, 1, 0, 1, 3'b000, 32'hFFFF_FFFC, 0);
        step(0, 1, 0, 0, 3'b000, 0, 0);
        check("t6_wrap_pc", pc_f, 32'h0);
        check("t6_wrap_pc4", pcplus4_d, 32'h0);
        step(0, 1, 1, 0, 3'b000, 0, 0);
        step(1, 1, 1, 0, 3'b000, 0, 0);
        check("t6_rst_pc", pc_f, 32'h0);
        check("t6_rst_req", {31'd0, imem_req}, 32'd0);
        step(0, 1, 0, 0, 3'b000, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_rdy, r_stl, r_psrc;
            logic [2:0]  r_jmp;
            r_rst  = ($urandom_range(0, 99) == 0);
            r_rdy  = ($urandom_range(0, 3) != 0);
            r_stl  = ($urandom_range(0, 4) == 0);
            r_psrc = ($urandom_range(0, 7) == 0);
            r_jmp  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            step(r_rst, r_rdy, r_stl, r_psrc, r_jmp, $urandom & 32'hFFFF_FFFC, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
